svm_detection_collector: RTL

Downstream consumer of the SVM accumulator stage. Takes one signed window score per detection window and tags it with (x, y) window coordinates from internal raster counters. Compares each score against a per-frame threshold and queues positive windows in a FIFO. Detections are presented on a valid/ready port to the bounding-box/overlay logic.

---
 rtl/svm_detection_collector_if.sv | 28 ++
 rtl/svm_detection_collector.sv | 132 +++++++++++++
 2 files changed

// File: rtl/svm_detection_collector_if.sv
// Detection output port of the SVM collector: one queued window hit per transfer.
// The master presents the head entry and the slave accepts it on det_valid && det_ready.
interface svm_detection_collector_if #(
    parameter int ACC_WIDTH   = 44,
    parameter int COORD_WIDTH = 10
);
    logic                   det_valid;
    logic                   det_ready;
    logic [COORD_WIDTH-1:0] det_x;
    logic [COORD_WIDTH-1:0] det_y;
    logic [ACC_WIDTH-1:0]   det_score;

    modport master (
        output det_valid,
        output det_x,
        output det_y,
        output det_score,
        input  det_ready
    );

    modport slave (
        input  det_valid,
        input  det_x,
        input  det_y,
        input  det_score,
        output det_ready
    );
endinterface

// File: rtl/svm_detection_collector.sv
// Tags SVM window scores with raster (x, y), thresholds them against a per-frame value
// and queues hits in a FIFO for the bounding-box stage. Score-to-FIFO latency is 2 cycles.
module svm_detection_collector #(
    parameter int ACC_WIDTH       = 44,
    parameter int COORD_WIDTH     = 10,
    parameter int WINDOWS_PER_ROW = 53,
    parameter int WINDOW_ROWS     = 29,
    parameter int FIFO_DEPTH      = 16,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   frame_start_i,
    input  logic [ACC_WIDTH-1:0]   threshold_i,
    input  logic                   score_de_i,
    input  logic [ACC_WIDTH-1:0]   score_i,
    svm_detection_collector_if.master det_if,
    output logic                   frame_done_o,
    output logic                   overflow_o,
    output logic [COUNT_WIDTH-1:0] det_count_o
);
    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W    = 2 * COORD_WIDTH + ACC_WIDTH;
    localparam logic [COORD_WIDTH-1:0] LAST_X = COORD_WIDTH'(WINDOWS_PER_ROW - 1);
    localparam logic [COORD_WIDTH-1:0] LAST_Y = COORD_WIDTH'(WINDOW_ROWS - 1);
    localparam logic [AW:0]            FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    logic [COORD_WIDTH-1:0] x_q, x_d, y_q, y_d, cur_x, cur_y;
    logic [ACC_WIDTH-1:0]   thr_q, thr_d, thr_eff;
    logic                   hit_now, last_now;

    logic                   s1_hit_q, frame_done_q;
    logic [COORD_WIDTH-1:0] s1_x_q, s1_y_q;
    logic [ACC_WIDTH-1:0]   s1_score_q;

    logic [ENTRY_W-1:0]     mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0]     head;
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [AW:0]            cnt_q, cnt_d;
    logic                   fifo_full, pop, wr_en, drop;

    logic                   overflow_q, overflow_d;
    logic [COUNT_WIDTH-1:0] det_count_q, det_count_d;

    // frame_start re-bases the raster so a coincident strobe is window (0,0)
    // and is judged against the threshold being loaded for the new frame.
    always_comb begin
        cur_x   = frame_start_i ? '0 : x_q;
        cur_y   = frame_start_i ? '0 : y_q;
        thr_eff = frame_start_i ? threshold_i : thr_q;
        thr_d   = thr_eff;
        x_d     = cur_x;
        y_d     = cur_y;
        if (score_de_i) begin
            if (cur_x == LAST_X) begin
                x_d = '0;
                y_d = (cur_y == LAST_Y) ? '0 : cur_y + 1'b1;
            end else begin
                x_d = cur_x + 1'b1;
            end
        end
        hit_now  = score_de_i && ($signed(score_i) > $signed(thr_eff));
        last_now = score_de_i && (cur_x == LAST_X) && (cur_y == LAST_Y);
    end

    always_comb begin
        fifo_full = (cnt_q == FULL_CNT);
        pop       = (cnt_q != '0) && det_if.det_ready;
        wr_en     = s1_hit_q && (!fifo_full || pop);
        drop      = s1_hit_q && !wr_en;
        cnt_d     = cnt_q + (AW + 1)'(wr_en) - (AW + 1)'(pop);
    end

    // A drop or accepted write in the frame_start cycle still lands after the clear.
    always_comb begin
        overflow_d  = (frame_start_i ? 1'b0 : overflow_q) | drop;
        det_count_d = frame_start_i ? '0 : det_count_q;
        if (wr_en && det_count_d != COUNT_MAX) begin
            det_count_d = det_count_d + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q          <= '0;
            y_q          <= '0;
            thr_q        <= '0;
            s1_hit_q     <= 1'b0;
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            s1_score_q   <= '0;
            frame_done_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            overflow_q   <= 1'b0;
            det_count_q  <= '0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            thr_q        <= thr_d;
            s1_hit_q     <= hit_now;
            s1_x_q       <= cur_x;
            s1_y_q       <= cur_y;
            s1_score_q   <= score_i;
            frame_done_q <= last_now;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q        <= cnt_d;
            overflow_q   <= overflow_d;
            det_count_q  <= det_count_d;
        end
    end

    // Storage carries no reset; stale words are never visible because outputs are gated by occupancy.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= {s1_x_q, s1_y_q, s1_score_q};
    end

    always_comb begin
        head             = (cnt_q != '0) ? mem[rd_ptr_q] : '0;
        det_if.det_valid = (cnt_q != '0);
        det_if.det_x     = head[ENTRY_W-1 -: COORD_WIDTH];
        det_if.det_y     = head[ACC_WIDTH +: COORD_WIDTH];
        det_if.det_score = head[ACC_WIDTH-1:0];
    end

    assign frame_done_o = frame_done_q;
    assign overflow_o   = overflow_q;
    assign det_count_o  = det_count_q;
endmodule
